// File: rtl/uart_pkg.sv
// Shared UART constants: data width, clocking and the default echo-path FIFO depth.
package uart_pkg;
  localparam int UART_DATA_W    = 8;
  localparam int CLK_HZ         = 100_000_000;
  localparam int BIT_RATE       = 9600;
  localparam int CLKS_PER_BIT   = CLK_HZ / BIT_RATE;
  localparam int FIFO_DEPTH     = 16;
endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage with wrapping read/write pointers and an asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between UART RX and TX: strobe write side, valid/ready read side, occupancy and loss flags.
// Optional drop counter output is enabled by defining UART_RX_FIFO_DROP_CNT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AFULL_LVL = 12
) (
  input  logic                     clk_i,
  input  logic                     nreset_i,
  input  logic                     wr_valid_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_ready_i,
  output logic                     rd_valid_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     afull_o,
  output logic                     overflow_o,
`ifdef UART_RX_FIFO_DROP_CNT_EN
  output logic [7:0]               drop_cnt_o,
`endif
  input  logic                     ovf_clr_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  // Handshake: a byte leaves when rd_valid_o && rd_ready_i at a clock edge; rd_data_o is
  // held stable while rd_valid_o=1 and rd_ready_i=0. The write side is a non-stallable strobe.
  logic          rd_fire;
  logic          wr_accept;
  logic          wr_drop;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;

  assign rd_valid_o = (count_q != '0);
  assign rd_fire    = rd_valid_o && rd_ready_i;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign wr_accept  = wr_valid_i && ((count_q < DEPTH_C) || rd_fire);
  assign wr_drop    = wr_valid_i && !wr_accept;
  assign count_o    = count_q;

  always_comb begin
    count_next = count_q;
    if (wr_accept && !rd_fire)      count_next = count_q + CW'(1);
    else if (!wr_accept && rd_fire) count_next = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      count_q    <= '0;
      afull_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      count_q <= count_next;
      afull_o <= (count_next >= AFULL_C);
      if (wr_drop)        overflow_o <= 1'b1;
      else if (ovf_clr_i) overflow_o <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      drop_cnt_q <= '0;
    end else if (ovf_clr_i) begin
      drop_cnt_q <= wr_drop ? 8'd1 : 8'd0;
    end else if (wr_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk_i),
    .nreset  (nreset_i),
    .wr_en   (wr_accept),
    .wr_data (wr_data_i),
    .rd_en   (rd_fire),
    .rd_data (rd_data_o)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with an expected-byte queue as scoreboard.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         nreset_i = 1'b0;
  logic         wr_valid_i = 1'b0;
  logic [W-1:0] wr_data_i = '0;
  logic         rd_ready_i = 1'b0;
  logic         rd_valid_o;
  logic [W-1:0] rd_data_o;
  logic [4:0]   count_o;
  logic         afull_o;
  logic         overflow_o;
  logic         ovf_clr_i = 1'b0;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0]   drop_cnt_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  // Clock and reset
  always #5 clk_i = ~clk_i;

  uart_rx_fifo #(.DATA_W(W), .DEPTH(16), .AFULL_LVL(12)) dut (
    .clk_i      (clk_i),
    .nreset_i   (nreset_i),
    .wr_valid_i (wr_valid_i),
    .wr_data_i  (wr_data_i),
    .rd_ready_i (rd_ready_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .count_o    (count_o),
    .afull_o    (afull_o),
    .overflow_o (overflow_o),
`ifdef UART_RX_FIFO_DROP_CNT_EN
    .drop_cnt_o (drop_cnt_o),
`endif
    .ovf_clr_i  (ovf_clr_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are observed at that same point.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_byte(input logic [W-1:0] b);
    wr_valid_i = 1'b1;
    wr_data_i  = b;
    exp_q.push_back(b);
    step();
    wr_valid_i = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    logic [W-1:0] e;
    rd_ready_i = 1'b1;
    for (int guard = 0; guard < 40 && exp_q.size() > 0; guard++) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(rd_valid_o), 32'd1);
      check({tag, "_data"}, 32'(rd_data_o), 32'(e));
      step();
    end
    rd_ready_i = 1'b0;
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_count0"}, 32'(count_o), 32'd0);
    check({tag, "_valid0"}, 32'(rd_valid_o), 32'd0);
  endtask

  task automatic do_reset();
    nreset_i = 1'b0;
    step();
    nreset_i = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    #1;
    nreset_i = 1'b0;
    step();
    step();
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_valid", 32'(rd_valid_o), 32'd0);
    check("rst_afull", 32'(afull_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    nreset_i = 1'b1;

    // Empty plus ready: nothing happens
    rd_ready_i = 1'b1;
    step();
    rd_ready_i = 1'b0;
    check("empty_rd_count", 32'(count_o), 32'd0);
    check("empty_rd_valid", 32'(rd_valid_o), 32'd0);

    // Three bytes, held at the head while not ready
    write_byte(8'h41);
    write_byte(8'h42);
    write_byte(8'h43);
    check("three_count", 32'(count_o), 32'd3);
    check("three_valid", 32'(rd_valid_o), 32'd1);
    check("three_head", 32'(rd_data_o), 32'h41);
    step();
    check("three_hold", 32'(rd_data_o), 32'h41);
    drain_all("three");

    // Fill then overflow
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    check("full_count", 32'(count_o), 32'd16);
    check("full_afull", 32'(afull_o), 32'd1);
    wr_valid_i = 1'b1;
    wr_data_i  = 8'hAA;
    step();
    wr_valid_i = 1'b0;
    check("drop_ovf", 32'(overflow_o), 32'd1);
    check("drop_count", 32'(count_o), 32'd16);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt_o), 32'd1);
`endif
    drain_all("fill");
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    ovf_clr_i = 1'b1;
    step();
    ovf_clr_i = 1'b0;
    check("ovf_clr", 32'(overflow_o), 32'd0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    check("drop_cnt_clr", 32'(drop_cnt_o), 32'd0);
`endif

    // Full with simultaneous write and read
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    check("sim_head", 32'(rd_data_o), 32'h00);
    void'(exp_q.pop_front());
    wr_valid_i = 1'b1;
    wr_data_i  = 8'h55;
    rd_ready_i = 1'b1;
    exp_q.push_back(8'h55);
    step();
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    check("sim_count", 32'(count_o), 32'd16);
    check("sim_ovf", 32'(overflow_o), 32'd0);
    check("sim_next_head", 32'(rd_data_o), 32'h01);
    drain_all("sim");

    // Almost-full threshold
    for (int i = 0; i < 11; i++) write_byte(8'(8'h20 + i));
    check("af11_count", 32'(count_o), 32'd11);
    check("af11_afull", 32'(afull_o), 32'd0);
    write_byte(8'h2B);
    check("af12_count", 32'(count_o), 32'd12);
    check("af12_afull", 32'(afull_o), 32'd1);
    rd_ready_i = 1'b1;
    check("af_rd_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
    step();
    rd_ready_i = 1'b0;
    check("af_rd_count", 32'(count_o), 32'd11);
    check("af_rd_afull", 32'(afull_o), 32'd0);
    drain_all("af");

    // 20 writes with a read every other cycle, wrapping the pointers
    for (int i = 0; i < 20; i++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = 8'(8'h80 + 3 * i);
      rd_ready_i = i[0];
      if (rd_ready_i && rd_valid_o)
        check("wrap_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
      exp_q.push_back(wr_data_i);
      step();
    end
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    check("wrap_count", 32'(count_o), 32'd10);
    drain_all("wrap");

    // Reset mid-operation
    for (int i = 0; i < 5; i++) write_byte(8'(8'hC0 + i));
    check("pre_rst_count", 32'(count_o), 32'd5);
    do_reset();
    check("mid_rst_count", 32'(count_o), 32'd0);
    check("mid_rst_valid", 32'(rd_valid_o), 32'd0);
    check("mid_rst_ovf", 32'(overflow_o), 32'd0);
    write_byte(8'h7E);
    check("post_rst_head", 32'(rd_data_o), 32'h7E);
    check("post_rst_count", 32'(count_o), 32'd1);
    drain_all("post_rst");

    // Drop and clear in the same cycle: the drop wins
    for (int i = 0; i < 16; i++) write_byte(8'(8'hE0 + i));
    wr_valid_i = 1'b1;
    wr_data_i  = 8'hBB;
    ovf_clr_i  = 1'b1;
    step();
    wr_valid_i = 1'b0;
    ovf_clr_i  = 1'b0;
    check("setclr_ovf", 32'(overflow_o), 32'd1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
    check("setclr_cnt", 32'(drop_cnt_o), 32'd1);
`endif
    drain_all("setclr");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Byte buffer between the UART receiver and the UART transmitter in the loopback/echo path. It absorbs bursts of received bytes so none are lost while the transmitter is busy sending a 10-bit frame. The write side takes a single-cycle strobe, because the RX line cannot be stalled. The read side is a valid/ready handshake into the TX data input. It also reports occupancy, almost-full (usable as an RTS hint) and overflow status.

Parameters:
DATA_W, 8, byte width
DEPTH, 16, number of entries; power of two, minimum 2
AFULL_LVL, 12, occupancy at or above which afull_o asserts; range 1..DEPTH

Ports:
clk_i  input  1  system clock, 100 MHz
nreset_i  input  1  reset; synchronous, active-low
wr_valid_i  input  1  one-cycle strobe: wr_data_i holds a received byte
wr_data_i  input  DATA_W  received byte
rd_ready_i  input  1  transmitter ready to take a byte
rd_valid_o  output  1  head entry available
rd_data_o  output  DATA_W  head entry (show-ahead)
count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
afull_o  output  1  count_o >= AFULL_LVL
overflow_o  output  1  sticky: a write was dropped because the FIFO was full
ovf_clr_i  input  1  clears overflow_o

Behaviour:
- Reset: synchronous, active-low.
  - Sampled on posedge clk_i while nreset_i=0: read/write pointers, count_o, overflow_o and drop counter go to 0.
  - Outputs during and after reset: rd_valid_o=0, afull_o=0; rd_data_o is don't-care while rd_valid_o=0.
  - Reset mid-operation discards all stored bytes immediately; no partial state survives.
- Storage: DEPTH x DATA_W register array.
  - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
  - Occupancy is a separate counter, width $clog2(DEPTH)+1, so full and empty are unambiguous.
- Write: accepted when wr_valid_i=1 and (count_o<DEPTH or a read handshake occurs in the same cycle).
  - Accepted write: store wr_data_i at the write pointer, then advance the write pointer.
- Read handshake: rd_valid_o && rd_ready_i.
  - The read pointer advances on the next edge.
  - rd_data_o = mem[rd_ptr], combinational from the registered pointer; it is stable while rd_valid_o=1 and rd_ready_i=0.
- Valid: rd_valid_o = (count_o != 0), i.e. registered count.
- Latency: a byte written at edge N shows rd_valid_o=1 after edge N (visible in cycle N+1). There is no empty-bypass.
- Count update (next count):
  - count+1 on write only.
  - count-1 on read only.
  - unchanged on simultaneous write+read, including when full.
- Full plus write without a read in the same cycle:
  - the byte is dropped and memory is unchanged;
  - overflow_o is set on the next edge.
- Empty plus rd_ready_i: no effect. Pointers never underflow.
- overflow_o: set by a drop, cleared by ovf_clr_i. Same-cycle set and clear: set wins.
- afull_o: registered, derived from the next-state count, so it matches count_o in the same cycle.
- Ordering: strict FIFO.

Optional Feature:
- Macro: UART_RX_FIFO_DROP_CNT_EN.
- Defined:
  - adds output drop_cnt_o [7:0]: number of dropped writes, saturating at 255;
  - cleared by reset and by ovf_clr_i; a same-cycle drop and clear yields 1.
- Undefined: port and counter are absent; overflow_o alone reports loss.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8, CLK_HZ=100_000_000, BIT_RATE=9600;
  - derived CLKS_PER_BIT;
  - the default FIFO depth constant.
- Storage and pointer logic live in one natural sub-module, uart_fifo_mem: register array, write port, asynchronous read port.
- Count, flags and handshake logic stay in uart_rx_fifo.

Test Plan:
- Reset, then write 0x41, 0x42, 0x43 on consecutive cycles with rd_ready_i=0 -> count_o=3, rd_valid_o=1, rd_data_o=0x41 and held stable.
- Then rd_ready_i=1 for 3 cycles -> rd_data_o sequence 0x41, 0x42, 0x43; count_o=0, rd_valid_o=0 afterwards.
- Fill 16 bytes 0x00..0x0F, then write 0xAA -> 0xAA dropped; overflow_o=1; drop_cnt_o=1 when the macro is defined.
- Drain order is 0x00..0x0F; pulse ovf_clr_i -> overflow_o=0.
- When full, simultaneous write 0x55 and read -> 0x00 is read, 0x55 is accepted, count_o stays 16, overflow_o stays 0.
- Write 12 bytes -> afull_o rises in the same cycle count_o=12; one read -> afull_o=0 at count_o=11.
- Write 20 bytes while reading every other cycle, forcing pointer wrap -> output matches a reference queue exactly.
- Assert nreset_i=0 for one cycle with count_o=5 -> count_o=0, rd_valid_o=0, overflow_o=0.
- After reset, write 0x7E -> it is read back first.
